// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Two requesters share one UART TX line. A round-robin arbiter picks a
//   requester, latches its byte on the grant edge and sends it as an 8N1 frame.
//   The bit rate comes from a bit-enable counter that divides sys_clk. There is
//   no derived clock.
//
// Ports
//   sys_clk        system clock, rising edge
//   reset          asynchronous reset, active low
//   req0/data0     requester 0 request and byte; data held stable while req0 is high
//   ack0           one-cycle pulse when requester 0's byte is accepted
//   req1/data1     requester 1 request and byte
//   ack1           one-cycle pulse when requester 1's byte is accepted
//   tx             serial output, idles high
//   busy           high while a frame is on the line
//   last_grant     index of the most recently served requester
//
// BAUD_DIV is the number of sys_clk cycles per bit. Legal range is 2..8191.
module uart_tx_arbiter #(
  parameter int BAUD_DIV = 5208
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       req0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       ack1,
  output logic       tx,
  output logic       busy,
  output logic       last_grant
);

  localparam logic [12:0] BAUD_LAST = 13'(BAUD_DIV - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state;
  logic [9:0]  shift;     // {stop, data[7:0], start}; bit 0 drives the line
  logic [12:0] baud_cnt;
  logic [3:0]  bit_cnt;

  logic grant_any;
  logic grant_idx;

  // On contention, grant the requester that was not served last.
  // With a single request, grant that requester.
  always_comb begin
    grant_any = req0 | req1;
    grant_idx = (req0 && req1) ? ~last_grant : req1;
  end

  // tx comes straight from a register bit. Reset fills shift with ones, so
  // tx goes high asynchronously. A completed frame also leaves all ones
  // behind, so the line idles high without extra logic.
  assign tx = shift[0];

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      shift      <= '1;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      busy       <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            ack0       <= ~grant_idx;
            ack1       <= grant_idx;
            last_grant <= grant_idx;
            shift      <= {1'b1, (grant_idx ? data1 : data0), 1'b0};
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            busy       <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            shift    <= {1'b1, shift[9:1]};
            bit_cnt  <= bit_cnt + 4'd1;
            // The stop bit has now lasted a full bit period.
            if (bit_cnt == 4'd9) begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 13'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int BD     = 4;
  localparam int BD_BIG = 5208;

  logic       sys_clk = 1'b0;
  logic       reset   = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  logic       ack0, ack1, tx, busy, last_grant;

  logic       big_req0 = 1'b0, big_req1 = 1'b0;
  logic [7:0] big_data0 = 8'h00, big_data1 = 8'h00;
  logic       big_ack0, big_ack1, big_tx, big_busy, big_last_grant;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic m_last   = 1'b1;   // model of the round-robin history

  always #5 sys_clk = ~sys_clk;

  uart_tx_arbiter #(.BAUD_DIV(BD)) dut (
    .sys_clk(sys_clk), .reset(reset),
    .req0(req0), .data0(data0), .ack0(ack0),
    .req1(req1), .data1(data1), .ack1(ack1),
    .tx(tx), .busy(busy), .last_grant(last_grant)
  );

  uart_tx_arbiter dut_big (
    .sys_clk(sys_clk), .reset(reset),
    .req0(big_req0), .data0(big_data0), .ack0(big_ack0),
    .req1(big_req1), .data1(big_data1), .ack1(big_ack1),
    .tx(big_tx), .busy(big_busy), .last_grant(big_last_grant)
  );

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Expected line levels for one 8N1 frame: start, data LSB first, stop.
  function automatic logic [9:0] frame_of(input logic [7:0] b);
    logic [9:0] f;
    f[0] = 1'b0;
    for (int k = 0; k < 8; k++) f[k+1] = b[k];
    f[9] = 1'b1;
    return f;
  endfunction

  task automatic step();
    @(posedge sys_clk); #1;
  endtask

  task automatic wait_ack(input int bound, output int waited, output bit got);
    got = 0; waited = 0;
    while (!got && waited < bound) begin
      step(); waited++;
      if (ack0 || ack1) got = 1;
    end
  endtask

  // Observation only. It starts at the ack cycle and ends on the first
  // cycle after the frame. It records the level of each bit, whether every
  // bit held for the whole period, busy cycles, and any acks after the first.
  task automatic capture(output logic [9:0] bits, output bit stable,
                         output int busy_len, output int extra_acks);
    logic [9:0] b;
    b = '1; stable = 1; busy_len = 0; extra_acks = 0;
    for (int i = 0; i < 10*BD; i++) begin
      if (i % BD == 0) b[i/BD] = tx;
      else if (tx !== b[i/BD]) stable = 0;
      if (busy === 1'b1) busy_len++;
      if (i > 0 && (ack0 || ack1)) extra_acks++;
      step();
    end
    bits = b;
  endtask

  task automatic test_reset();
    reset = 1'b0; step(); step();
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if ({ack0, ack1} !== 2'b00) begin n_fail++; $display("FAIL reset_acks: got %b want 00", {ack0, ack1}); end
    n_checks++; if (last_grant !== 1'b1) begin n_fail++; $display("FAIL reset_last_grant: got %b want 1", last_grant); end
    reset = 1'b1; m_last = 1'b1; step(); step();
    n_checks++; if ({tx, busy} !== 2'b10) begin n_fail++; $display("FAIL reset_idle: got tx,busy=%b want 10", {tx, busy}); end
  endtask

  task automatic test_single_byte();
    int w; bit got; logic [9:0] bits; bit st; int bl, ex;
    data0 = 8'hA5; req0 = 1'b1;
    wait_ack(5, w, got);
    req0 = 1'b0;
    n_checks++; if (!got || w != 1) begin n_fail++; $display("FAIL single_latency: got %0d cycles (ack=%0b) want 1", w, got); end
    n_checks++; if ({ack0, ack1} !== 2'b10) begin n_fail++; $display("FAIL single_ack: got %b want 10", {ack0, ack1}); end
    n_checks++; if (last_grant !== 1'b0) begin n_fail++; $display("FAIL single_last_grant: got %b want 0", last_grant); end
    m_last = 1'b0;
    capture(bits, st, bl, ex);
    n_checks++; if (bits !== 10'h34A) begin n_fail++; $display("FAIL single_bits: got %b want %b", bits, 10'h34A); end
    n_checks++; if (!st) begin n_fail++; $display("FAIL single_bit_hold: got unstable want %0d-cycle bits", BD); end
    n_checks++; if (bl != 40) begin n_fail++; $display("FAIL single_busy_len: got %0d want 40", bl); end
    n_checks++; if (ex != 0) begin n_fail++; $display("FAIL single_extra_ack: got %0d want 0", ex); end
    n_checks++; if ({tx, busy} !== 2'b10) begin n_fail++; $display("FAIL single_after: got tx,busy=%b want 10", {tx, busy}); end
  endtask

  task automatic test_simultaneous();
    int w; bit got; logic [9:0] bits; bit st; int bl, ex; logic g;
    reset = 1'b0; step(); reset = 1'b1; m_last = 1'b1;
    data0 = 8'h11; data1 = 8'h22; req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      g = ~m_last;
      wait_ack(10*BD + 5, w, got);
      n_checks++; if (!got || w != 1) begin n_fail++; $display("FAIL simul_gap%0d: got %0d cycles want 1", k, w); end
      n_checks++; if ({ack1, ack0} !== {g, ~g}) begin n_fail++; $display("FAIL simul_order%0d: got ack1,ack0=%b want %b", k, {ack1, ack0}, {g, ~g}); end
      n_checks++; if (last_grant !== g) begin n_fail++; $display("FAIL simul_last_grant%0d: got %b want %b", k, last_grant, g); end
      m_last = g;
      capture(bits, st, bl, ex);
      n_checks++; if (bits !== frame_of(g ? 8'h22 : 8'h11) || !st || bl != 40)
        begin n_fail++; $display("FAIL simul_frame%0d: got %b busy %0d want %b busy 40", k, bits, bl, frame_of(g ? 8'h22 : 8'h11)); end
      if (k == 3) begin req0 = 1'b0; req1 = 1'b0; end
    end
  endtask

  task automatic test_req_during_send();
    int w; bit got; logic [9:0] bits; bit st; int bl, ex; int early;
    data0 = 8'($urandom); req0 = 1'b1;
    wait_ack(5, w, got);
    req0 = 1'b0; m_last = 1'b0;
    n_checks++; if (!got || ack0 !== 1'b1) begin n_fail++; $display("FAIL send_req_ack0: got %b want 1", ack0); end
    early = 0;
    for (int i = 0; i < 10*BD; i++) begin
      if (i == 10) begin data1 = 8'($urandom); req1 = 1'b1; end
      if (ack1) early++;
      step();
    end
    n_checks++; if (early != 0 || ack1 !== 1'b0) begin n_fail++; $display("FAIL send_req_early_ack1: got %0d acks want 0", early); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL send_req_idle: got busy %b want 0", busy); end
    step();
    n_checks++; if (ack1 !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL send_req_ack1: got ack1,busy=%b want 11", {ack1, busy}); end
    req1 = 1'b0; m_last = 1'b1;
    capture(bits, st, bl, ex);
    n_checks++; if (bits !== frame_of(data1) || !st || bl != 40) begin n_fail++; $display("FAIL send_req_frame: got %b want %b", bits, frame_of(data1)); end
  endtask

  task automatic test_reset_mid_frame();
    int w; bit got; logic [9:0] bits; bit st; int bl, ex;
    data0 = 8'($urandom); req0 = 1'b1;
    wait_ack(5, w, got);
    req0 = 1'b0;
    for (int i = 0; i < 5*BD + 1; i++) step();
    reset = 1'b0; #1;
    n_checks++; if ({tx, busy, ack0, ack1} !== 4'b1000) begin n_fail++; $display("FAIL midreset_outputs: got tx,busy,ack0,ack1=%b want 1000", {tx, busy, ack0, ack1}); end
    n_checks++; if (last_grant !== 1'b1) begin n_fail++; $display("FAIL midreset_last_grant: got %b want 1", last_grant); end
    m_last = 1'b1;
    data1 = 8'($urandom); req1 = 1'b1;
    @(negedge sys_clk); reset = 1'b1;
    wait_ack(5, w, got);
    req1 = 1'b0;
    n_checks++; if (!got || {ack1, ack0} !== 2'b10) begin n_fail++; $display("FAIL midreset_regrant: got ack1,ack0=%b want 10", {ack1, ack0}); end
    m_last = 1'b1;
    capture(bits, st, bl, ex);
    n_checks++; if (bits !== frame_of(data1) || !st || bl != 40) begin n_fail++; $display("FAIL midreset_frame: got %b busy %0d want %b busy 40", bits, bl, frame_of(data1)); end
  endtask

  task automatic test_data_change();
    int w; bit got; logic [9:0] bits; bit st; int bl, ex; logic [7:0] x;
    x = 8'($urandom); data0 = x; req0 = 1'b1;
    wait_ack(5, w, got);
    req0 = 1'b0; data0 = ~x; m_last = 1'b0;
    capture(bits, st, bl, ex);
    n_checks++; if (!got || bits !== frame_of(x)) begin n_fail++; $display("FAIL data_change: got %b want %b", bits, frame_of(x)); end
  endtask

  task automatic test_random();
    int w; bit got; logic [9:0] bits; bit st; int bl, ex; logic [1:0] pat; logic g; logic [7:0] exp_b;
    for (int it = 0; it < 24; it++) begin
      for (int gap = $urandom_range(0, 3); gap > 0; gap--) step();
      pat = 2'($urandom_range(1, 3));
      data0 = 8'($urandom); data1 = 8'($urandom);
      req0 = pat[0]; req1 = pat[1];
      g = (pat == 2'b11) ? ~m_last : pat[1];
      exp_b = g ? data1 : data0;
      wait_ack(5, w, got);
      req0 = 1'b0; req1 = 1'b0;
      n_checks++; if (!got || w != 1 || {ack1, ack0} !== {g, ~g} || last_grant !== g)
        begin n_fail++; $display("FAIL rand_grant%0d: got ack1,ack0,lg=%b%b%b want %b%b%b", it, ack1, ack0, last_grant, g, ~g, g); end
      m_last = g;
      capture(bits, st, bl, ex);
      n_checks++; if (bits !== frame_of(exp_b) || !st || bl != 40 || ex != 0)
        begin n_fail++; $display("FAIL rand_frame%0d: got %b busy %0d want %b busy 40", it, bits, bl, frame_of(exp_b)); end
    end
  endtask

  task automatic test_default_div();
    int w; int low, high, bl;
    big_data0 = 8'h00; big_req0 = 1'b1;
    w = 0;
    while (big_ack0 !== 1'b1 && w < 5) begin step(); w++; end
    big_req0 = 1'b0;
    n_checks++; if (big_ack0 !== 1'b1) begin n_fail++; $display("FAIL bigdiv_ack: got %b want 1", big_ack0); end
    low = 0; high = 0; bl = 0;
    while (big_tx === 1'b0 && low < 60000) begin low++; if (big_busy === 1'b1) bl++; step(); end
    while (big_tx === 1'b1 && big_busy === 1'b1 && high < 10000) begin high++; bl++; step(); end
    n_checks++; if (low != 9*BD_BIG) begin n_fail++; $display("FAIL bigdiv_low: got %0d want %0d", low, 9*BD_BIG); end
    n_checks++; if (high != BD_BIG) begin n_fail++; $display("FAIL bigdiv_high: got %0d want %0d", high, BD_BIG); end
    n_checks++; if (bl != 10*BD_BIG) begin n_fail++; $display("FAIL bigdiv_busy: got %0d want %0d", bl, 10*BD_BIG); end
    n_checks++; if ({big_tx, big_busy} !== 2'b10) begin n_fail++; $display("FAIL bigdiv_after: got tx,busy=%b want 10", {big_tx, big_busy}); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_simultaneous();
    test_req_during_send();
    test_reset_mid_frame();
    test_data_change();
    test_random();
    test_default_div();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
